// File: rtl/hdmi_pkg.sv
// hdmi_pkg: packet type codes, slots per audio sample packet and the stereo sample type
package hdmi_pkg;
  localparam logic [7:0] PACKET_TYPE_NULL = 8'd0;
  localparam logic [7:0] PACKET_TYPE_AUDIO_SAMPLE = 8'd2;
  localparam int SAMPLES_PER_PACKET = 4;
  localparam int AUDIO_BIT_WIDTH_DEFAULT = 16;
  typedef logic [1:0][AUDIO_BIT_WIDTH_DEFAULT-1:0] stereo_sample_t;
endpackage

// File: rtl/multi_pop_fifo.sv
// multi_pop_fifo: single-push, up-to-four-pop FIFO exposing its four oldest entries in parallel
module multi_pop_fifo
  import hdmi_pkg::*;
#(
  parameter int W = 16,
  parameter int DEPTH = 8,
  parameter int LW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [1:0][W-1:0] push_data,
  input  logic [LW-1:0] pop_n,
  output logic [SAMPLES_PER_PACKET-1:0][1:0][W-1:0] oldest,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0][W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_comb begin
    oldest = '0;
    for (int i = 0; i < SAMPLES_PER_PACKET; i++) oldest[i] = mem[rd_ptr + AW'(i)];
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= push_data;
  // DEPTH is a power of two, so plain pointer arithmetic wraps correctly
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop_n);
      level <= level - pop_n + LW'(push);
    end
  end
endmodule

// File: rtl/audio_sample_buffer.sv
// audio_sample_buffer: queues stereo PCM samples and hands up to four per packet slot to hdmi
module audio_sample_buffer
  import hdmi_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic sample_valid,
  input  logic [AUDIO_BIT_WIDTH-1:0] sample_left,
  input  logic [AUDIO_BIT_WIDTH-1:0] sample_right,
  input  logic packet_enable,
  output logic [3:0][1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
  output logic [3:0] audio_sample_word_present,
  output logic [7:0] packet_type,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic overflow
);
  localparam int LW = $clog2(DEPTH + 1);
  logic [LW-1:0] pop_n, take;
  logic accept;
  logic [3:0][1:0][AUDIO_BIT_WIDTH-1:0] oldest;
  assign pop_n = level > LW'(SAMPLES_PER_PACKET) ? LW'(SAMPLES_PER_PACKET) : level;
  assign take = packet_enable ? pop_n : '0;
  // a same-cycle pop frees room before the push is judged
  assign accept = sample_valid && (level - take) < LW'(DEPTH);
  multi_pop_fifo #(.W(AUDIO_BIT_WIDTH), .DEPTH(DEPTH), .LW(LW)) fifo (
    .clk(clk_pixel),
    .rst(reset),
    .push(accept),
    .push_data({sample_right, sample_left}),
    .pop_n(take),
    .oldest(oldest),
    .level(level)
  );
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      audio_sample_word <= '0;
      audio_sample_word_present <= '0;
      packet_type <= PACKET_TYPE_NULL;
      overflow <= 1'b0;
    end else begin
      overflow <= sample_valid && !accept;
      if (packet_enable) begin
        for (int i = 0; i < 4; i++) begin
          audio_sample_word[i] <= LW'(i) < pop_n ? oldest[i] : '0;
          audio_sample_word_present[i] <= LW'(i) < pop_n;
        end
        packet_type <= pop_n != '0 ? PACKET_TYPE_AUDIO_SAMPLE : PACKET_TYPE_NULL;
      end
    end
  end
endmodule

// File: doc/audio_sample_buffer.md
Name: audio_sample_buffer

Overview:
- Upstream feeder for the hdmi top module's audio path.
- Accepts one stereo PCM sample per strobe, already in the clk_pixel domain, and queues it in a FIFO.
- On each packet slot (packet_enable from hdmi), pops up to four samples and presents them as audio_sample_word / audio_sample_word_present / packet_type for the next audio sample packet.
- Absorbs jitter between the audio sample rate and the data-island packet schedule.

Parameters:
- AUDIO_BIT_WIDTH, 16: bits per channel sample; must equal the hdmi AUDIO_BIT_WIDTH.
- DEPTH, 8: FIFO capacity in stereo samples; power of two, minimum 4.

Ports:
- clk_pixel  input  1  pixel clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe; sample_left/sample_right are valid.
- sample_left  input  AUDIO_BIT_WIDTH  left channel sample.
- sample_right  input  AUDIO_BIT_WIDTH  right channel sample.
- packet_enable  input  1  packet slot pulse from hdmi.
- audio_sample_word  output  [3:0][1:0][AUDIO_BIT_WIDTH-1:0]  slot i, channel 0 = left, channel 1 = right.
- audio_sample_word_present  output  [3:0]  per-slot valid bits.
- packet_type  output  8  8'd2 (audio sample) if any slot is present, else 8'd0 (null).
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  output  1  one-cycle pulse when an incoming sample is dropped.

Behaviour:
- Reset (synchronous, active-high), including mid-operation:
  - FIFO emptied; pointers and level go to 0.
  - All output words 0, present 4'b0000, packet_type 8'd0, overflow 0.
  - Any sample_valid or packet_enable in the reset cycle is ignored.
- Pop, on a rising edge with packet_enable=1:
  - pop_n = min(level, 4), using level before this cycle's push.
  - Slots 0..pop_n-1 load the oldest samples in FIFO order; slot 0 is the oldest.
  - Slots pop_n..3 load word 0, present bit 0.
  - audio_sample_word_present = (1<<pop_n)-1, so present bits are always contiguous from bit 0.
  - packet_type = 2 if pop_n>0, else 0.
- Latency: outputs change only on a packet_enable edge and hold until the next one. The set loaded at packet_enable N is consumed by hdmi in packet N+1, i.e. one packet of latency by design.
- Push, on a rising edge with sample_valid=1:
  - Accepted iff (level - pop_n) < DEPTH, so a same-cycle pop frees space first.
  - If rejected: sample dropped, overflow=1 for that cycle only, level unchanged by the push.
- A sample pushed in the same cycle as packet_enable is never part of that cycle's pop; it lands behind existing entries.
- level(next) = level - pop_n + accepted_push. It never exceeds DEPTH and never underflows.
- Pointers wrap modulo DEPTH. Occupancy comes from the explicit level counter, not pointer comparison, so full and empty are unambiguous.
- No FSM states beyond the FIFO and output registers. All outputs are registered; nothing is combinational from inputs to outputs.

Decomposition:
- Shared package (hdmi_pkg) holds:
  - PACKET_TYPE_NULL = 8'd0 and PACKET_TYPE_AUDIO_SAMPLE = 8'd2.
  - SAMPLES_PER_PACKET = 4.
  - A typedef for one stereo sample (a [1:0] array of AUDIO_BIT_WIDTH-bit words).
- One sub-module, multi_pop_fifo: single-push, up-to-4-pop FIFO with a level counter and parallel read of the four oldest entries.
- The parent holds the output registers, the pop_n computation and the overflow pulse.

Test Plan:
- Reset: assert reset for 2 cycles after random pushes → level=0, present=4'b0000, packet_type=0, all words 0, overflow=0.
- Partial packet:
  - Stimulus: push (L,R)=(16'h0001,16'h8001), (16'h0002,16'h8002), (16'h0003,16'h8003); then pulse packet_enable.
  - Response: present=4'b0111, slot0=(0001,8001), slot1=(0002,8002), slot2=(0003,8003), slot3=0, packet_type=2, level=0.
- Multi-packet drain:
  - Stimulus: push 6 samples; pulse packet_enable twice.
  - Response: first pulse gives present=4'b1111 with samples 1-4 and level=2; second gives present=4'b0011 with samples 5-6 and level=0.
  - Outputs stay stable between pulses.
- Empty slot: packet_enable with level=0 → present=4'b0000, packet_type=0, words 0.
- Overflow: DEPTH=8, push 9 samples with no pop → overflow pulses only on the 9th push, level=8. A following pop returns samples 1-4, proving the 9th was dropped.
- Simultaneous events:
  - At level=8, assert sample_valid and packet_enable in the same cycle → pop 4, push accepted, no overflow, level=5.
  - The new sample appears in slot 0 of the second subsequent packet.
  - Then assert reset during a push → level=0 and the sample is not stored.
